// File: rtl/ascon_perm_sched.sv
// Round-robin scheduler sharing one ASCON permutation core between two requesters.
// Sequences core load (ctr=0), rnd round cycles (ctr=1..rnd), then holds the result until taken.
module ascon_perm_sched #(
  parameter int MAX_ROUNDS = 12,
  parameter int RW         = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [319:0]  req0_state,
  input  logic [RW-1:0] req0_rounds,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [319:0]  req1_state,
  input  logic [RW-1:0] req1_rounds,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [319:0]  rsp_state,
  output logic          rsp_err,
  output logic [319:0]  perm_S,
  output logic          perm_start,
  output logic [RW-1:0] perm_ctr,
  output logic [RW-1:0] perm_rounds,
  input  logic [319:0]  perm_out,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t        state_reg, state_next;
  logic [RW-1:0] cnt_reg, cnt_next;
  logic [RW-1:0] rnd_reg, rnd_next;
  logic          owner_reg, owner_next;
  logic          err_reg, err_next;
  logic          last_grant_reg, last_grant_next;

  logic          grant_valid;
  logic          grant_id;
  logic [319:0]  sel_state;
  logic [RW-1:0] sel_rounds;
  logic          sel_illegal;
  logic          owner_rsp_ready;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant_reg;
    end else begin
      grant_id = req1_valid;
    end
    sel_state       = grant_id ? req1_state : req0_state;
    sel_rounds      = grant_id ? req1_rounds : req0_rounds;
    sel_illegal     = (sel_rounds == '0) || (sel_rounds > RW'(MAX_ROUNDS));
    owner_rsp_ready = owner_reg ? rsp1_ready : rsp0_ready;
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    rnd_next        = rnd_reg;
    owner_next      = owner_reg;
    err_next        = err_reg;
    last_grant_next = last_grant_reg;
    req0_ready      = 1'b0;
    req1_ready      = 1'b0;
    rsp0_valid      = 1'b0;
    rsp1_valid      = 1'b0;
    rsp_state       = '0;
    rsp_err         = 1'b0;
    perm_S          = '0;
    perm_start      = 1'b0;
    perm_ctr        = '0;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          req0_ready      = ~grant_id;
          req1_ready      = grant_id;
          perm_start      = 1'b1;
          perm_S          = sel_state;
          owner_next      = grant_id;
          last_grant_next = grant_id;
          rnd_next        = sel_rounds;
          err_next        = sel_illegal;
          cnt_next        = RW'(1);
          state_next      = sel_illegal ? RESP : RUN;
        end
      end
      RUN: begin
        perm_start = 1'b1;
        perm_ctr   = cnt_reg;
        if (cnt_reg == rnd_reg) begin
          cnt_next   = '0;
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RESP: begin
        // Core is idle here, so perm_out holds the final (or just-loaded) state.
        rsp_state  = perm_out;
        rsp_err    = err_reg;
        rsp0_valid = ~owner_reg;
        rsp1_valid = owner_reg;
        if (owner_rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      rnd_reg        <= '0;
      owner_reg      <= 1'b0;
      err_reg        <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      rnd_reg        <= rnd_next;
      owner_reg      <= owner_next;
      err_reg        <= err_next;
      last_grant_reg <= last_grant_next;
    end
  end

  assign perm_rounds = rnd_reg;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_ascon_perm_sched.sv
// Directed bench for ascon_perm_sched with a behavioural ASCON round core and reference permutation.
module tb_ascon_perm_sched;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [319:0]  req0_state, req1_state;
  logic [4:0]    req0_rounds, req1_rounds;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [319:0]  rsp_state, perm_S, perm_out;
  logic          rsp_err, perm_start, busy;
  logic [4:0]    perm_ctr, perm_rounds;
  logic [319:0]  core_q;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int tb_last;

  always #5 clk = ~clk;

  ascon_perm_sched #(.MAX_ROUNDS(12), .RW(5)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_state(req0_state), .req0_rounds(req0_rounds),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_state(req1_state), .req1_rounds(req1_rounds),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_state(rsp_state), .rsp_err(rsp_err), .perm_S(perm_S), .perm_start(perm_start),
    .perm_ctr(perm_ctr), .perm_rounds(perm_rounds), .perm_out(perm_out), .busy(busy)
  );

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // One ASCON round with round-constant index i (0..11).
  function automatic logic [319:0] ascon_round(input logic [319:0] s, input int i);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x2 = x2 ^ 64'(((15 - i) << 4) | i);
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [319:0] ascon_p(input logic [319:0] s, input int r);
    logic [319:0] v = s;
    for (int i = 12 - r; i < 12; i++) v = ascon_round(v, i);
    return v;
  endfunction

  // Core model: load on ctr=0, one round per enabled cycle otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) core_q <= '0;
    else if (perm_start) begin
      if (perm_ctr == 5'd0) core_q <= perm_S;
      else core_q <= ascon_round(core_q, 12 - int'(perm_rounds) + int'(perm_ctr) - 1);
    end
  end
  assign perm_out = core_q;

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_state = '0; req1_state = '0; req0_rounds = 0; req1_rounds = 0;
    tick(); tick();
    chk("rst_busy", 320'(busy), 320'(0));
    chk("rst_start", 320'(perm_start), 320'(0));
    chk("rst_rounds", 320'(perm_rounds), 320'(0));
    chk("rst_rsp", 320'({rsp0_valid, rsp1_valid, rsp_err}), 320'(0));
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 320'({req0_ready, req1_ready}), 320'(0));
    chk("post_rst_state", rsp_state, 320'(0));
    chk("post_rst_permS", perm_S, 320'(0));
  endtask

  // Runs one job for requester g from the IDLE cycle through to the following IDLE cycle.
  task automatic do_job(input int g, input logic [319:0] st, input logic [4:0] r, input int hold);
    logic [319:0] exp_s;
    logic         exp_e;
    logic         rv_g, rv_o;
    exp_e = (r == 5'd0) || (r > 5'd12);
    exp_s = exp_e ? st : ascon_p(st, int'(r));
    if (g == 0) begin req0_valid = 1; req0_state = st; req0_rounds = r; end
    else        begin req1_valid = 1; req1_state = st; req1_rounds = r; end
    #1;
    chk("grant_ready", 320'(g == 0 ? req0_ready : req1_ready), 320'(1));
    chk("other_ready", 320'(g == 0 ? req1_ready : req0_ready), 320'(0));
    chk("acc_start", 320'(perm_start), 320'(1));
    chk("acc_ctr", 320'(perm_ctr), 320'(0));
    chk("acc_permS", perm_S, st);
    tick();
    if (g == 0) begin req0_valid = 0; req0_state = {10{$urandom}}; req0_rounds = 5'd31; end
    else        begin req1_valid = 0; req1_state = {10{$urandom}}; req1_rounds = 5'd31; end
    if (!exp_e) begin
      for (int k = 1; k <= int'(r); k++) begin
        chk("run_ctr", 320'(perm_ctr), 320'(k));
        chk("run_ctl", 320'({perm_start, busy, perm_rounds}), 320'({2'b11, r}));
        chk("run_idle", 320'({rsp0_valid, rsp1_valid, req0_ready, req1_ready}), 320'(0));
        chk("run_permS", perm_S, 320'(0));
        tick();
      end
    end
    for (int h = 0; h <= hold; h++) begin
      rv_g = (g == 0) ? rsp0_valid : rsp1_valid;
      rv_o = (g == 0) ? rsp1_valid : rsp0_valid;
      chk("rsp_valid", 320'({rv_g, rv_o}), 320'(2'b10));
      chk("rsp_state", rsp_state, exp_s);
      chk("rsp_err", 320'(rsp_err), 320'(exp_e));
      chk("rsp_hold", 320'({perm_start, req0_ready, req1_ready, perm_ctr}), 320'(0));
      if (h < hold) begin
        if (g == 0) rsp1_ready = 1; else rsp0_ready = 1;
        tick();
      end
    end
    if (g == 0) begin rsp0_ready = 1; rsp1_ready = 0; end
    else        begin rsp1_ready = 1; rsp0_ready = 0; end
    tick();
    rsp0_ready = 0; rsp1_ready = 0;
    chk("back_idle", 320'({busy, rsp0_valid, rsp1_valid}), 320'(0));
    $display("job g=%0d rounds=%0d hold=%0d err=%0d done", g, r, hold, exp_e);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [319:0] s_iv, a, b;
    int g, both, winner;
    logic [4:0] rr0, rr1;
    s_iv = {64'h80400c0600000000, 256'h0};
    a = {10{32'hdeadbeef}};
    b = {10{32'h01234567}};

    // T1: single 12-round job after reset
    do_reset();
    do_job(0, s_iv, 5'd12, 0);

    // T2: ties alternate, starting with requester 0
    do_reset();
    req1_valid = 1; req1_state = b; req1_rounds = 5'd8;
    do_job(0, a, 5'd6, 0);
    chk("t2_r1_pending", 320'(req1_valid), 320'(1));
    do_job(1, b, 5'd8, 0);
    req1_valid = 1; req1_state = a; req1_rounds = 5'd6;
    do_job(0, b, 5'd12, 0);
    do_job(1, a, 5'd6, 0);

    // T3: response stalled for 10 cycles
    do_job(1, b ^ a, 5'd6, 10);

    // T4: illegal round counts
    do_job(0, a, 5'd0, 0);
    do_job(1, b, 5'd13, 2);

    // T5: reset while running
    do_reset();
    req0_valid = 1; req0_state = a; req0_rounds = 5'd12;
    tick();
    req0_valid = 0;
    tick(); tick(); tick(); tick();
    chk("t5_ctr5", 320'(perm_ctr), 320'(5));
    reset = 1;
    #1;
    chk("t5_ctl", 320'({busy, perm_start, perm_ctr, perm_rounds}), 320'(0));
    chk("t5_rsp", 320'({rsp0_valid, rsp1_valid, rsp_err}), 320'(0));
    chk("t5_state", rsp_state, 320'(0));
    tick();
    reset = 0;
    tick();
    do_job(0, b, 5'd8, 0);
    tb_last = 0;

    // T6: random back-to-back traffic
    for (int n = 0; n < 12; n++) begin
      g    = int'($urandom_range(0, 1));
      both = ($urandom_range(0, 2) == 0) ? 1 : 0;
      rr0  = (n % 3 == 0) ? 5'd6 : ((n % 3 == 1) ? 5'd8 : 5'd12);
      rr1  = (n % 2 == 0) ? 5'd12 : 5'd6;
      req0_state = {10{$urandom}}; req0_rounds = rr0;
      req1_state = {10{$urandom}}; req1_rounds = rr1;
      winner = both ? (1 - tb_last) : g;
      req0_valid = (both != 0) || (g == 0);
      req1_valid = (both != 0) || (g == 1);
      if (winner == 0) do_job(0, req0_state, rr0, int'($urandom_range(0, 2)));
      else             do_job(1, req1_state, rr1, int'($urandom_range(0, 2)));
      tb_last = winner;
    end
    req0_valid = 0; req1_valid = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
